pipeline_ctrl: RTL and testbench

Central stall/flush responder for the 5-stage rv32 pipeline. It consumes the load-use stall request from the hazard unit, the EX-stage branch/jump redirect, the instruction-fetch response, and the data-memory busy signal. From these it drives write-enables, bubble-inserting flushes and PC redirect controls for every pipeline register. It also tracks the branch-during-outstanding-fetch case with a small FSM and keeps stall/flush performance counters.

---
 rtl/pipeline_ctrl_if.sv | 39 +++
 rtl/pipeline_ctrl.sv | 101 ++++++++++
 tb/tb_pipeline_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the hazard/fetch/memory side and the pipeline stall/flush controller.
interface pipeline_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             load_use_stall_i;
    logic             branch_taken_i;
    logic [XLEN-1:0]  redirect_pc_i;
    logic             imem_ready_i;
    logic             mem_busy_i;
    logic             perf_clr_i;
    logic             pc_we_o;
    logic             pc_redirect_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             if_id_we_o;
    logic             id_ex_we_o;
    logic             ex_mem_we_o;
    logic             if_id_flush_o;
    logic             id_ex_flush_o;
    logic             mem_wb_flush_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output load_use_stall_i, branch_taken_i, redirect_pc_i, imem_ready_i,
               mem_busy_i, perf_clr_i,
        input  pc_we_o, pc_redirect_o, redirect_pc_o, if_id_we_o, id_ex_we_o,
               ex_mem_we_o, if_id_flush_o, id_ex_flush_o, mem_wb_flush_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  load_use_stall_i, branch_taken_i, redirect_pc_i, imem_ready_i,
               mem_busy_i, perf_clr_i,
        output pc_we_o, pc_redirect_o, redirect_pc_o, if_id_we_o, id_ex_we_o,
               ex_mem_we_o, if_id_flush_o, id_ex_flush_o, mem_wb_flush_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush responder for the 5-stage rv32 pipeline: zero-latency enables/flushes,
// a RUN/KILL_PEND FSM for redirects racing an outstanding fetch, and perf counters.
module pipeline_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    pipeline_ctrl_if.slave  ctl
);
    typedef enum logic {RUN, KILL_PEND} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             flush_acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        tgt_d              = tgt_q;
        flush_acc          = 1'b0;
        ctl.pc_we_o        = 1'b1;
        ctl.pc_redirect_o  = 1'b0;
        ctl.redirect_pc_o  = ctl.redirect_pc_i;
        ctl.if_id_we_o     = 1'b1;
        ctl.id_ex_we_o     = 1'b1;
        ctl.ex_mem_we_o    = 1'b1;
        ctl.if_id_flush_o  = 1'b0;
        ctl.id_ex_flush_o  = 1'b0;
        ctl.mem_wb_flush_o = 1'b0;
        case (state_q)
            RUN: begin
                if (ctl.mem_busy_i) begin
                    // EX is frozen and keeps presenting its branch; it is taken once memory frees up
                    ctl.pc_we_o        = 1'b0;
                    ctl.if_id_we_o     = 1'b0;
                    ctl.id_ex_we_o     = 1'b0;
                    ctl.ex_mem_we_o    = 1'b0;
                    ctl.mem_wb_flush_o = 1'b1;
                end else if (ctl.branch_taken_i && ctl.imem_ready_i) begin
                    ctl.pc_redirect_o = 1'b1;
                    ctl.if_id_flush_o = 1'b1;
                    ctl.id_ex_flush_o = 1'b1;
                    flush_acc         = 1'b1;
                end else if (ctl.branch_taken_i) begin
                    // Fetch still in flight: park the target until the stale response lands
                    ctl.pc_we_o       = 1'b0;
                    ctl.if_id_flush_o = 1'b1;
                    ctl.id_ex_flush_o = 1'b1;
                    tgt_d             = ctl.redirect_pc_i;
                    state_d           = KILL_PEND;
                    flush_acc         = 1'b1;
                end else if (ctl.load_use_stall_i) begin
                    ctl.pc_we_o       = 1'b0;
                    ctl.if_id_we_o    = 1'b0;
                    ctl.id_ex_flush_o = 1'b1;
                end else if (!ctl.imem_ready_i) begin
                    ctl.pc_we_o       = 1'b0;
                    ctl.if_id_flush_o = 1'b1;
                end
            end
            KILL_PEND: begin
                ctl.pc_redirect_o  = 1'b1;
                ctl.redirect_pc_o  = tgt_q;
                ctl.if_id_flush_o  = 1'b1;
                ctl.ex_mem_we_o    = !ctl.mem_busy_i;
                ctl.mem_wb_flush_o = ctl.mem_busy_i;
                ctl.pc_we_o        = ctl.imem_ready_i;
                if (ctl.imem_ready_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Clear wins over a same-cycle increment; both counters wrap naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (ctl.perf_clr_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!ctl.pc_we_o) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_acc)    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign ctl.stall_cnt_o = stall_cnt_q;
    assign ctl.flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl: driver queues hand-derived expectations,
// a negedge monitor pops and compares each cycle's outputs.
module tb_pipeline_ctrl;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    // {pc_we, pc_redirect, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_flush}
    localparam logic [7:0] NRM = 8'b1_0_111_000;
    localparam logic [7:0] LU  = 8'b0_0_011_010;
    localparam logic [7:0] BRR = 8'b1_1_111_110;
    localparam logic [7:0] BRN = 8'b0_0_111_110;
    localparam logic [7:0] KPW = 8'b0_1_111_100;
    localparam logic [7:0] KPR = 8'b1_1_111_100;
    localparam logic [7:0] KPB = 8'b0_1_110_101;
    localparam logic [7:0] KRB = 8'b1_1_110_101;
    localparam logic [7:0] BSY = 8'b0_0_000_001;
    localparam logic [7:0] FNR = 8'b0_0_111_100;

    typedef struct {
        logic [7:0]       c;
        logic [XLEN-1:0]  rpc;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t q[$];
    exp_t e;
    int n_vec  = 0;
    int n_miss = 0;
    logic [CNT_W-1:0] ms = '0;
    logic [CNT_W-1:0] mf = '0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) ifc ();

    pipeline_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ctl    (ifc.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec %0d %s: got %0h expected %0h", n_vec, name, act, exp);
        end
    endtask

    // Flush overrides the matching enable, so enables are only checked where no flush is expected
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            chk("pc_we",        32'(ifc.pc_we_o),        32'(e.c[7]));
            chk("pc_redirect",  32'(ifc.pc_redirect_o),  32'(e.c[6]));
            chk("redirect_pc",  ifc.redirect_pc_o,       e.rpc);
            if (!e.c[2]) chk("if_id_we", 32'(ifc.if_id_we_o), 32'(e.c[5]));
            if (!e.c[1]) chk("id_ex_we", 32'(ifc.id_ex_we_o), 32'(e.c[4]));
            chk("ex_mem_we",    32'(ifc.ex_mem_we_o),    32'(e.c[3]));
            chk("if_id_flush",  32'(ifc.if_id_flush_o),  32'(e.c[2]));
            chk("id_ex_flush",  32'(ifc.id_ex_flush_o),  32'(e.c[1]));
            chk("mem_wb_flush", 32'(ifc.mem_wb_flush_o), 32'(e.c[0]));
            chk("stall_cnt",    32'(ifc.stall_cnt_o),    32'(e.sc));
            chk("flush_cnt",    32'(ifc.flush_cnt_o),    32'(e.fc));
        end
    end

    task automatic apply(input logic busy, input logic br, input logic rdy, input logic lu,
                         input logic clr, input logic [XLEN-1:0] pc, input logic [7:0] c,
                         input logic [XLEN-1:0] rpc, input logic acc, input logic rst_now);
        exp_t r;
        @(posedge clk);
        #1;
        ifc.mem_busy_i       = busy;
        ifc.branch_taken_i   = br;
        ifc.imem_ready_i     = rdy;
        ifc.load_use_stall_i = lu;
        ifc.perf_clr_i       = clr;
        ifc.redirect_pc_i    = pc;
        if (rst_now) begin
            #1 rst_n = 1'b0;
        end
        if (!rst_n) begin
            ms = '0;
            mf = '0;
        end
        r.c = c; r.rpc = rpc; r.sc = ms; r.fc = mf;
        q.push_back(r);
        if (rst_n) begin
            if (clr) begin
                ms = '0;
                mf = '0;
            end else begin
                ms = ms + CNT_W'(!c[7]);
                mf = mf + CNT_W'(acc);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ifc.mem_busy_i = 1'b0; ifc.branch_taken_i = 1'b0; ifc.imem_ready_i = 1'b1;
        ifc.load_use_stall_i = 1'b0; ifc.perf_clr_i = 1'b0; ifc.redirect_pc_i = '0;
        // In reset: RUN decode, counters zero
        apply(0, 0, 1, 0, 0, 32'h0, NRM, 32'h0, 0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        apply(0, 0, 1, 0, 0, 32'h44, NRM, 32'h44, 0, 0);
        // Load-use: one bubble
        apply(0, 0, 1, 1, 0, 32'h48, LU, 32'h48, 0, 0);
        apply(0, 0, 1, 0, 0, 32'h4c, NRM, 32'h4c, 0, 0);
        // Branch with fetch ready
        apply(0, 1, 1, 0, 0, 32'h100, BRR, 32'h100, 1, 0);
        apply(0, 0, 1, 0, 0, 32'h104, NRM, 32'h104, 0, 0);
        // Branch with fetch outstanding; branch/load-use ignored in KILL_PEND
        apply(0, 1, 0, 0, 0, 32'h200, BRN, 32'h200, 1, 0);
        apply(0, 1, 0, 1, 0, 32'hdead_0000, KPW, 32'h200, 0, 0);
        apply(0, 0, 0, 0, 0, 32'h300, KPW, 32'h200, 0, 0);
        apply(0, 0, 1, 0, 0, 32'h304, KPR, 32'h200, 0, 0);
        apply(0, 0, 1, 0, 0, 32'h204, NRM, 32'h204, 0, 0);
        // Memory busy masks branch and load-use; branch taken when busy drops
        for (int i = 0; i < 4; i++)
            apply(1, 1, 1, 1, 0, 32'h400, BSY, 32'h400, 0, 0);
        apply(0, 1, 1, 1, 0, 32'h400, BRR, 32'h400, 1, 0);
        apply(0, 0, 0, 0, 0, 32'h500, FNR, 32'h500, 0, 0);
        // KILL_PEND under memory busy, resolved while still busy
        apply(0, 1, 0, 0, 0, 32'h600, BRN, 32'h600, 1, 0);
        apply(1, 0, 0, 0, 0, 32'h604, KPB, 32'h600, 0, 0);
        apply(1, 0, 1, 0, 0, 32'h608, KRB, 32'h600, 0, 0);
        apply(0, 0, 1, 0, 0, 32'h60c, NRM, 32'h60c, 0, 0);
        // Async reset mid-KILL_PEND drops the pending redirect
        apply(0, 1, 0, 0, 0, 32'h700, BRN, 32'h700, 1, 0);
        apply(0, 0, 1, 0, 0, 32'h704, NRM, 32'h704, 0, 1);
        #5 rst_n = 1'b1;
        apply(0, 0, 1, 0, 0, 32'h708, NRM, 32'h708, 0, 0);
        // Counter wrap and clear
        apply(0, 1, 1, 0, 1, 32'h800, BRR, 32'h800, 1, 0);
        for (int i = 0; i < 17; i++)
            apply(0, 0, 0, 0, 0, 32'h900, FNR, 32'h900, 0, 0);
        apply(0, 0, 0, 0, 1, 32'h904, FNR, 32'h904, 0, 0);
        apply(0, 0, 1, 0, 0, 32'h908, NRM, 32'h908, 0, 0);
        apply(0, 0, 1, 0, 0, 32'h90c, NRM, 32'h90c, 0, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) $display("FAIL drain: %0d expectations left unchecked", q.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + q.size());
        $finish;
    end
endmodule
